// File: rtl/change_dispenser_if.sv
// Vend-controller / hopper side signals of the change dispenser.
// COIN_INVENTORY_EN adds the refill input and per-coin stock_empty flags.
interface change_dispenser_if #(
    parameter int VAL_W = 8
);
    logic             start;
    logic [VAL_W-1:0] change_val;
    logic             coin_ack;
    logic [3:0]       coin_out;
    logic             coin_valid;
    logic             busy;
    logic             done;
    logic             error;
    logic [VAL_W-1:0] remain;
`ifdef COIN_INVENTORY_EN
    logic             refill;
    logic [3:0]       stock_empty;

    modport master (
        output start, change_val, coin_ack, refill,
        input  coin_out, coin_valid, busy, done, error, remain, stock_empty
    );
    modport slave (
        input  start, change_val, coin_ack, refill,
        output coin_out, coin_valid, busy, done, error, remain, stock_empty
    );
`else
    modport master (
        output start, change_val, coin_ack,
        input  coin_out, coin_valid, busy, done, error, remain
    );
    modport slave (
        input  start, change_val, coin_ack,
        output coin_out, coin_valid, busy, done, error, remain
    );
`endif
endinterface

// File: rtl/change_dispenser.sv
// Greedy 50/20/10/5 change dispenser, one coin per valid/ack handshake.
// Optional COIN_INVENTORY_EN: per-denomination stock counters with refill.
module change_dispenser #(
    parameter int VAL_W      = 8,
    parameter int GAP_CYCLES = 1,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    change_dispenser_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, GAP, FINISH} state_t;

    localparam logic [VAL_W-1:0] V50 = VAL_W'(50);
    localparam logic [VAL_W-1:0] V20 = VAL_W'(20);
    localparam logic [VAL_W-1:0] V10 = VAL_W'(10);
    localparam logic [VAL_W-1:0] V5  = VAL_W'(5);
    localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t           state, state_nxt;
    logic [VAL_W-1:0] remain_q, remain_nxt, pick_src;
    logic [3:0]       coin_q, coin_nxt, pick, avail;
    logic [3:0]       gap_q, gap_nxt;

    function automatic logic [VAL_W-1:0] coin_value(input logic [3:0] c);
        case (c)
            4'b1000: coin_value = V50;
            4'b0100: coin_value = V20;
            4'b0010: coin_value = V10;
            4'b0001: coin_value = V5;
            default: coin_value = '0;
        endcase
    endfunction

`ifdef COIN_INVENTORY_EN
    logic [3:0][STOCK_W-1:0] stock;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stock <= {4{STOCK_W'(STOCK_INIT)}};
        end else if (state == IDLE && bus.refill) begin
            stock <= {4{STOCK_W'(STOCK_INIT)}};
        end else if (state == ISSUE && bus.coin_ack) begin
            for (int i = 0; i < 4; i++)
                if (coin_q[i]) stock[i] <= stock[i] - STOCK_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) avail[i] = (stock[i] != '0);
    end
    assign bus.stock_empty = ~avail;
`else
    assign avail = 4'b1111;
`endif

    // In IDLE the first coin is chosen straight from the request value.
    assign pick_src = (state == IDLE) ? bus.change_val : remain_q;

    always_comb begin
        pick = 4'b0000;
        if      (avail[3] && pick_src >= V50) pick = 4'b1000;
        else if (avail[2] && pick_src >= V20) pick = 4'b0100;
        else if (avail[1] && pick_src >= V10) pick = 4'b0010;
        else if (avail[0] && pick_src >= V5)  pick = 4'b0001;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            remain_q <= '0;
            coin_q   <= '0;
            gap_q    <= '0;
        end else begin
            state    <= state_nxt;
            remain_q <= remain_nxt;
            coin_q   <= coin_nxt;
            gap_q    <= gap_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        remain_nxt = remain_q;
        coin_nxt   = coin_q;
        gap_nxt    = gap_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    remain_nxt = bus.change_val;
                    coin_nxt   = pick;
                    state_nxt  = (pick != '0) ? ISSUE : FINISH;
                end
            end
            ISSUE: begin
                if (bus.coin_ack) begin
                    remain_nxt = remain_q - coin_value(coin_q);
                    coin_nxt   = '0;
                    gap_nxt    = '0;
                    state_nxt  = GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    coin_nxt  = pick;
                    state_nxt = (pick != '0) ? ISSUE : FINISH;
                end else begin
                    gap_nxt = gap_q + 4'd1;
                end
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.coin_out   = coin_q;
    assign bus.coin_valid = (state == ISSUE);
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == FINISH) && (remain_q == '0);
    assign bus.error      = (state == FINISH) && (remain_q != '0);
    assign bus.remain     = remain_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed + randomized bench for change_dispenser with a greedy reference model.
module tb_change_dispenser;
    localparam int VW  = 8;
    localparam int GAP = 2;
`ifdef COIN_INVENTORY_EN
    localparam int SI  = 1;
    localparam bit INV = 1'b1;
`else
    localparam int SI  = 15;
    localparam bit INV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cval[4] = '{5, 10, 20, 50};
    int   m_stock[4];

    change_dispenser_if #(.VAL_W(VW)) bus ();

    change_dispenser #(
        .VAL_W(VW), .GAP_CYCLES(GAP), .STOCK_W(4), .STOCK_INIT(SI)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Largest coin not above rem that is still in stock, or -1.
    function automatic int greedy(input int rem);
        for (int i = 3; i >= 0; i--)
            if (rem >= cval[i] && (!INV || m_stock[i] > 0)) return i;
        return -1;
    endfunction

    function automatic logic [3:0] model_empty();
        logic [3:0] e;
        for (int i = 0; i < 4; i++) e[i] = (m_stock[i] == 0);
        return e;
    endfunction

    task automatic restock();
        for (int i = 0; i < 4; i++) m_stock[i] = SI;
    endtask

    task automatic run_req(input int v, input int d, input bit poke);
        int rem;
        int idx;
        logic [3:0] exp_coin;
        rem = v;
        bus.start = 1'b1;
        bus.change_val = VW'(v);
        step();
        bus.start = 1'b0;
        idx = greedy(rem);
        while (idx >= 0) begin
            exp_coin = 4'b0001 << idx;
            chk("coin_valid", 32'(bus.coin_valid), 1);
            chk("coin_out", 32'(bus.coin_out), 32'(exp_coin));
            chk("remain_issue", 32'(bus.remain), rem);
            chk("busy_issue", 32'(bus.busy), 1);
            for (int i = 1; i < d; i++) begin
                if (poke && i == 1) begin
                    bus.start = 1'b1;
                    bus.change_val = VW'($urandom_range(0, 255));
                end
                step();
                bus.start = 1'b0;
                chk("hold_valid", 32'(bus.coin_valid), 1);
                chk("hold_coin", 32'(bus.coin_out), 32'(exp_coin));
            end
            bus.coin_ack = 1'b1;
            step();
            bus.coin_ack = 1'b0;
            rem -= cval[idx];
            m_stock[idx] -= INV ? 1 : 0;
            chk("gap_valid", 32'(bus.coin_valid), 0);
            chk("gap_coin", 32'(bus.coin_out), 0);
            chk("remain_ack", 32'(bus.remain), rem);
            for (int g = 1; g < GAP; g++) begin
                // stray ack in GAP must be ignored
                bus.coin_ack = 1'b1;
                step();
                bus.coin_ack = 1'b0;
                chk("gap_low", 32'(bus.coin_valid), 0);
            end
            step();
            idx = greedy(rem);
        end
        chk("fin_done", 32'(bus.done), (rem == 0) ? 1 : 0);
        chk("fin_error", 32'(bus.error), (rem != 0) ? 1 : 0);
        chk("fin_remain", 32'(bus.remain), rem);
        chk("fin_busy", 32'(bus.busy), 1);
        chk("fin_valid", 32'(bus.coin_valid), 0);
        step();
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_pulse", 32'({bus.done, bus.error}), 0);
`ifdef COIN_INVENTORY_EN
        chk("stock_empty", 32'(bus.stock_empty), 32'(model_empty()));
`endif
    endtask

    task automatic check_zero_outputs(input string tag);
        chk(tag, 32'({bus.coin_out, bus.coin_valid, bus.busy, bus.done, bus.error}), 0);
        chk({tag, "_remain"}, 32'(bus.remain), 0);
    endtask

    task automatic do_refill();
`ifdef COIN_INVENTORY_EN
        bus.refill = 1'b1;
        step();
        bus.refill = 1'b0;
        restock();
`endif
    endtask

    initial begin
        bus.start = 1'b0;
        bus.change_val = '0;
        bus.coin_ack = 1'b0;
`ifdef COIN_INVENTORY_EN
        bus.refill = 1'b0;
`endif
        restock();
        step();
        step();
        check_zero_outputs("reset");
        rst = 1'b1;
        step();

        // directed cases
        run_req(85, 1, 1'b0);
        run_req(0, 1, 1'b0);
        run_req(7, 1, 1'b0);
        do_refill();
        run_req(40, 5, 1'b0);
        do_refill();

        // reset while the second coin of 100 is presented
        bus.start = 1'b1;
        bus.change_val = VW'(100);
        step();
        bus.start = 1'b0;
        bus.coin_ack = 1'b1;
        step();
        bus.coin_ack = 1'b0;
        for (int g = 0; g < GAP; g++) step();
        chk("rst_pre_valid", 32'(bus.coin_valid), 1);
        #2 rst = 1'b0;
        #1 check_zero_outputs("rst_async");
        step();
        check_zero_outputs("rst_held");
        rst = 1'b1;
        restock();
        step();
        run_req(10, 1, 1'b0);

`ifdef COIN_INVENTORY_EN
        do_refill();
        run_req(100, 1, 1'b0);
        chk("inv_all_empty", 32'(bus.stock_empty), 32'hF);
        do_refill();
        chk("inv_refilled", 32'(bus.stock_empty), 0);
        run_req(5, 1, 1'b0);
`endif

        // back-to-back: start in the first IDLE cycle after FINISH
        run_req(55, 2, 1'b0);
        run_req(30, 1, 1'b0);

        // randomized requests against the model
        for (int n = 0; n < 25; n++) begin
            if (INV && ($urandom_range(0, 1) == 1)) do_refill();
            run_req(int'($urandom_range(0, 255)), int'($urandom_range(1, 4)),
                    1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Output-side counterpart of the coin acceptor in the vending machine: returns a requested change amount as a sequence of physical coins.
- Takes a change value from the vend controller and decomposes it greedily into 50/20/10/5 coins.
- Issues one coin at a time to the coin-hopper driver over a valid/ack handshake.
- Coin encoding matches the coin-acceptor one-hot: bit3=50, bit2=20, bit1=10, bit0=5.

Parameters:
- VAL_W, 8, width of change value and remaining-amount register.
- GAP_CYCLES, 1, idle cycles (coin_valid low) inserted after each acknowledged coin; legal range 1..15.
- STOCK_W, 4, width of each per-denomination stock counter (used only with the optional feature).
- STOCK_INIT, 15, reset value of each stock counter (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- change_val  input  VAL_W  amount to return, latched on accepted start.
- coin_ack  input  1  hopper has taken the presented coin.
- coin_out  output  4  one-hot coin being presented; 4'b0000 when not valid.
- coin_valid  output  1  coin_out is valid and held stable until acked.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse: dispensing finished, full amount returned.
- error  output  1  one-cycle pulse: dispensing finished, amount not fully returnable.
- remain  output  VAL_W  amount still owed; after error, holds the undispensable residue.

Behaviour:
- Reset, asserted asynchronously at any time including mid-dispense:
  - State goes to IDLE.
  - coin_out=0, coin_valid=0, busy=0, done=0, error=0, remain=0.
  - Any coin in flight is abandoned.
- States:
  - IDLE: waits for start.
  - ISSUE: presents a coin and waits for ack.
  - GAP: counts out GAP_CYCLES idle cycles.
  - FINISH: emits the done or error pulse.
- IDLE:
  - On an edge with start=1, latch remain<=change_val.
  - If change_val>=5, go to ISSUE and register coin_out = largest coin <= change_val, with coin_valid=1 from the next cycle. Start-to-coin_valid latency is 1 cycle.
  - If change_val<5, go to FINISH.
- ISSUE:
  - coin_out and coin_valid are held stable until coin_ack=1 is sampled.
  - On the ack edge: remain <= remain - coin value; coin_valid<=0; coin_out<=0; go to GAP.
  - coin_ack while not in ISSUE is ignored.
  - start while busy is ignored, with no queueing.
- GAP:
  - Stays GAP_CYCLES cycles.
  - Then, if remain>=5, goes to ISSUE with the new greedy coin.
  - Otherwise goes to FINISH.
- FINISH:
  - For one cycle, done=1 if remain==0, else error=1. done and error are never high together.
  - Then returns to IDLE.
  - busy falls in the same cycle the state returns to IDLE.
- Greedy selection:
  - Priority 50>20>10>5, comparison is unsigned on VAL_W bits.
  - remain never underflows; the residue after error is always <5.
- Back-to-back requests: start may be asserted in the first IDLE cycle after FINISH and is accepted.
- Zero request: start with change_val=0 gives done one cycle later (in FINISH), with no coins issued.

Optional Feature:
- Macro: COIN_INVENTORY_EN.
- When defined, four STOCK_W-bit stock counters exist, reset to STOCK_INIT.
- A counter decrements on each acked coin of its denomination.
- Greedy selection skips any denomination whose stock is 0.
- If no stocked coin <= remain exists and remain>0, go to FINISH and pulse error.
- Extra ports present only with the macro:
  - refill input 1: on a sampled high in IDLE only, all counters are set to STOCK_INIT.
  - stock_empty output 4: one bit per denomination, high when that counter is 0.
- When not defined: supply is unlimited, and neither the counters nor the extra ports exist.

Test Plan:
- change_val=85, ack 1 cycle after each coin_valid -> coin sequence 1000, 0100, 0010, 0001; remain steps 85, 35, 15, 5, 0; done pulse; error never asserted.
- change_val=0 -> no coin_valid; done one cycle after start; busy high exactly 1 cycle.
- change_val=7 -> one coin 0001; remain=2; error pulse, done stays 0.
- change_val=40, coin_ack delayed 5 cycles per coin -> coin_out 0100 held stable and coin_valid high for all 5 cycles; two 20 coins; GAP_CYCLES low cycles between them; done.
- change_val=100, rst asserted while second coin presented -> all outputs 0 immediately; next start with 10 dispenses a single 0010 and done.
- COIN_INVENTORY_EN with STOCK_INIT=1, change_val=100 -> coins 50, 20, 10, 5; error with remain=15; stock_empty=4'b1111; refill then change_val=5 -> 0001, done.
